// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the RV32I fetch stage: instruction constants and fetch FSM states.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_ENC  = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] HALT_ENC = 32'h0000_006F;  // jal x0,0

  typedef enum logic [1:0] {
    FS_RUN    = 2'd0,
    FS_HALTED = 2'd1,
    FS_FAULT  = 2'd2
  } fetch_state_e;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load captures a fetched word, flush inserts a bubble,
// neither holds (stall). Flush has priority over load.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q, pc4_q, instr_q;
  logic            valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      pc4_q   <= XLEN'(4);
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      pc4_q   <= pc_i + XLEN'(4);
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and RUN/HALTED/FAULT
// control in front of the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     IMEM_WORDS  = 256,
  parameter bit              HALT_DETECT = 1'b1,
  parameter logic [XLEN-1:0] NOP_INSTR   = NOP_ENC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output logic [XLEN-1:0] if_instr,
  output logic            if_valid,
  output logic            halted,
  output logic            fetch_fault
);

  localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_WORDS);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            load, flush;
  logic            pc_out_of_range;

  assign pc_out_of_range = {2'b00, pc_q[XLEN-1:2]} >= IMEM_LIMIT;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      FS_RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (misaligned(redirect_pc[1:0])) state_d = FS_FAULT;
          else                             pc_d    = redirect_pc;
        end else if (pc_out_of_range) begin
          flush   = 1'b1;
          state_d = FS_FAULT;
        end else if (!stall) begin
          load = 1'b1;
          pc_d = pc_q + XLEN'(4);
          if (HALT_DETECT && imem_instr == HALT_ENC) state_d = FS_HALTED;
        end
      end
      // Repeated flush is idempotent, so the bubble lands on the first edge and stays.
      FS_HALTED: flush = 1'b1;
      FS_FAULT:  ;
      default:   state_d = FS_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_unit_if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .flush_i(flush),
    .pc_i   (pc_q),
    .instr_i(imem_instr),
    .pc_o   (if_pc),
    .pc4_o  (if_pc4),
    .instr_o(if_instr),
    .valid_o(if_valid)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == FS_HALTED);
  assign fetch_fault = (state_q == FS_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model predicts IF/ID and status after
// every edge; a monitor compares them one step after each rising edge.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_006F;
  localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_pc, imem_addr, imem_instr, if_pc, if_pc4, if_instr;
  logic        if_valid, halted, fetch_fault;
  logic [31:0] mem [256];

  assign imem_instr = mem[imem_addr[9:2]];
  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (256),
    .HALT_DETECT(1'b1),
    .NOP_INSTR  (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_pc         (if_pc),
    .if_pc4        (if_pc4),
    .if_instr      (if_instr),
    .if_valid      (if_valid),
    .halted        (halted),
    .fetch_fault   (fetch_fault)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic        fault;
    logic [31:0] addr;
  } obs_t;

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // behavioural model state
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr;
  logic        m_valid;
  int          m_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = NOP;
    return w;
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit rv, input logic [31:0] rpc);
    logic [31:0] w;
    if (rst) begin
      m_pc = 32'h0; m_mode = M_RUN;
      m_ifpc = 32'h0; m_ifpc4 = 32'h4; m_instr = NOP; m_valid = 1'b0;
    end else if (m_mode == M_RUN) begin
      w = mem[m_pc[9:2]];
      if (rv) begin
        m_valid = 1'b0; m_instr = NOP;
        if (rpc % 4 != 0) m_mode = M_FAULT;
        else              m_pc = rpc;
      end else if (m_pc / 4 >= 256) begin
        m_mode = M_FAULT; m_valid = 1'b0; m_instr = NOP;
      end else if (!st) begin
        m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_instr = w; m_valid = 1'b1;
        m_pc = m_pc + 4;
        if (w == HALT) m_mode = M_HALT;
      end
    end else if (m_mode == M_HALT) begin
      m_valid = 1'b0; m_instr = NOP;
    end
  endtask

  // Drive one cycle's inputs at a falling edge and queue the expected post-edge view.
  task automatic cycle(input bit rst, input bit st, input bit rv, input logic [31:0] rpc);
    obs_t e;
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc;
    if (rst) begin
      #1;
      chk("async_rst_halted", {31'b0, halted}, 32'h0);
      chk("async_rst_fault", {31'b0, fetch_fault}, 32'h0);
      chk("async_rst_valid", {31'b0, if_valid}, 32'h0);
      chk("async_rst_addr", imem_addr, 32'h0);
    end
    model_step(rst, st, rv, rpc);
    e = '{pc: m_ifpc, pc4: m_ifpc4, instr: m_instr, valid: m_valid,
          halted: (m_mode == M_HALT), fault: (m_mode == M_FAULT), addr: m_pc};
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    obs_t e, g;
    forever begin
      @(posedge clk);
      #1;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: no expectation queued at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        g = '{pc: if_pc, pc4: if_pc4, instr: if_instr, valid: if_valid,
              halted: halted, fault: fetch_fault, addr: imem_addr};
        if (g !== e) begin
          n_fail++;
          $display("FAIL edge_view at %0t: got pc=%08h pc4=%08h instr=%08h v=%b h=%b f=%b addr=%08h expected pc=%08h pc4=%08h instr=%08h v=%b h=%b f=%b addr=%08h",
                   $time, g.pc, g.pc4, g.instr, g.valid, g.halted, g.fault, g.addr,
                   e.pc, e.pc4, e.instr, e.valid, e.halted, e.fault, e.addr);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int r;
    logic [31:0] tgt;
    for (int i = 0; i < 256; i++) mem[i] = rnd_word();
    mem[0] = 32'h00A0_0093; mem[1] = 32'h0140_0113;
    mem[2] = 32'h0020_81B3; mem[3] = 32'h0031_2023;
    mem[5] = HALT;

    cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
    chk("rst_if_pc4", if_pc4, 32'h4);
    chk("rst_if_instr", if_instr, NOP);

    // sequential fetch and stall
    cycle(0, 0, 0, 0);
    chk("seq0_pc", if_pc, 32'h0); chk("seq0_instr", if_instr, 32'h00A0_0093);
    chk("seq0_valid", {31'b0, if_valid}, 32'h1);
    cycle(0, 0, 0, 0);
    chk("seq1_pc", if_pc, 32'h4); chk("seq1_instr", if_instr, 32'h0140_0113);
    for (int k = 0; k < 2; k++) begin
      cycle(0, 1, 0, 0);
      chk("stall_pc", if_pc, 32'h4); chk("stall_instr", if_instr, 32'h0140_0113);
      chk("stall_addr", imem_addr, 32'h8);
    end
    cycle(0, 0, 0, 0);
    chk("seq2_pc", if_pc, 32'h8); chk("seq2_instr", if_instr, 32'h0020_81B3);
    cycle(0, 0, 0, 0);
    chk("seq3_pc", if_pc, 32'hC); chk("seq3_instr", if_instr, 32'h0031_2023);
    chk("seq3_addr", imem_addr, 32'h10);

    // redirect beats stall
    cycle(0, 1, 1, 32'h24);
    chk("redir_valid", {31'b0, if_valid}, 32'h0); chk("redir_instr", if_instr, NOP);
    chk("redir_addr", imem_addr, 32'h24);
    cycle(0, 0, 0, 0);
    chk("redir_pc", if_pc, 32'h24);

    // halt idiom at word 5
    cycle(0, 0, 1, 32'h14);
    cycle(0, 0, 0, 0);
    chk("halt_pc", if_pc, 32'h14); chk("halt_valid", {31'b0, if_valid}, 32'h1);
    chk("halt_instr", if_instr, HALT);
    cycle(0, 0, 0, 0);
    chk("halted_valid", {31'b0, if_valid}, 32'h0); chk("halted_flag", {31'b0, halted}, 32'h1);
    cycle(0, 0, 1, 32'h14);
    chk("halted_ignore_redir", imem_addr, 32'h18);

    // async reset while halted, then misaligned redirect
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_0402);
    chk("misalign_fault", {31'b0, fetch_fault}, 32'h1);
    chk("misalign_valid", {31'b0, if_valid}, 32'h0);
    chk("misalign_addr", imem_addr, 32'h4);
    cycle(0, 0, 1, 32'h8);
    chk("fault_frozen", imem_addr, 32'h4);

    // run off the end of memory
    for (int i = 0; i < 256; i++) mem[i] = rnd_word();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 256; i++) cycle(0, 0, 0, 0);
    chk("last_pc", if_pc, 32'h3FC); chk("last_valid", {31'b0, if_valid}, 32'h1);
    chk("last_addr", imem_addr, 32'h400);
    chk("last_nofault", {31'b0, fetch_fault}, 32'h0);
    cycle(0, 0, 0, 0);
    chk("oob_fault", {31'b0, fetch_fault}, 32'h1);
    chk("oob_valid", {31'b0, if_valid}, 32'h0);
    chk("oob_addr", imem_addr, 32'h400);

    // randomized traffic
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 39) == 0) ? HALT : rnd_word();
    cycle(1, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      if ((m_mode != M_RUN && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        cycle(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      end else begin
        r = $urandom_range(0, 19);
        if (r == 0)      tgt = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
        else if (r == 1) tgt = 32'h400 + {$urandom_range(0, 63), 2'b00};
        else             tgt = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        cycle(0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, tgt);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
